// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//
// Shares one sequential divider between two result requesters. Jobs are
// taken one at a time, with round-robin fairness when both requesters are
// valid. Each job either launches the divider with a one-cycle start pulse
// and waits for its done strobe, or, if the denominator is zero, completes
// at once without touching the divider. A job whose divider does not finish
// within TIMEOUT cycles completes with the timeout flag set.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The source holds valid and its payload until that edge.
// The sink may raise or drop ready at any time. This rule applies to both
// request ports (reqN_valid_i / reqN_ready_o) and to the result port
// (res_valid_o / res_ready_i).
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   reqN_valid_i/ready_o      job handshake for requester N (0 or 1)
//   reqN_numer_i/denom_i      requester N operands
//   div_start_o               one-cycle launch pulse to the divider
//   div_numer_o/denom_o       operands of the current job (held until next accept)
//   div_done_i, div_quot_i    divider completion strobe and quotient
//   res_valid_o/ready_i       result handshake
//   res_id_o                  requester that owns the result
//   res_quot_o                quotient (all-ones on divide-by-zero, 0 on timeout)
//   res_divzero_o             the denominator was zero
//   res_timeout_o             the divider did not finish in time
//   busy_o                    a job is in progress (state is not IDLE)
//   state_o                   current FSM state, for debug
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [W-1:0] req0_numer_i,
    input  logic [W-1:0] req0_denom_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [W-1:0] req1_numer_i,
    input  logic [W-1:0] req1_denom_i,
    output logic         div_start_o,
    output logic [W-1:0] div_numer_o,
    output logic [W-1:0] div_denom_o,
    input  logic         div_done_i,
    input  logic [W-1:0] div_quot_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic         res_id_o,
    output logic [W-1:0] res_quot_o,
    output logic         res_divzero_o,
    output logic         res_timeout_o,
    output logic         busy_o,
    output logic [1:0]   state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Last value the wait counter reaches before the job is abandoned.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_e         state_q;
    logic           last_grant_q;
    logic [15:0]    wait_cnt_q;
    logic           div_start_q;
    logic [W-1:0]   div_numer_q;
    logic [W-1:0]   div_denom_q;
    logic           res_valid_q;
    logic           res_id_q;
    logic [W-1:0]   res_quot_q;
    logic           res_divzero_q;
    logic           res_timeout_q;

    logic           grant_id;
    logic           accept;
    logic [W-1:0]   sel_numer;
    logic [W-1:0]   sel_denom;

    // On a tie the requester that was not served last wins; otherwise the
    // only valid requester is granted (grant_id is a don't-care with none).
    always_comb begin
        grant_id = req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant_id = ~last_grant_q;
        end
    end

    assign req0_ready_o = (state_q == S_IDLE) && req0_valid_i && !grant_id;
    assign req1_ready_o = (state_q == S_IDLE) && req1_valid_i && grant_id;
    assign accept       = req0_ready_o || req1_ready_o;
    assign sel_numer    = grant_id ? req1_numer_i : req0_numer_i;
    assign sel_denom    = grant_id ? req1_denom_i : req0_denom_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            wait_cnt_q    <= '0;
            div_start_q   <= 1'b0;
            div_numer_q   <= '0;
            div_denom_q   <= '0;
            res_valid_q   <= 1'b0;
            res_id_q      <= 1'b0;
            res_quot_q    <= '0;
            res_divzero_q <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            // The start pulse is only ever raised for the single ISSUE cycle.
            div_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        div_numer_q  <= sel_numer;
                        div_denom_q  <= sel_denom;
                        last_grant_q <= grant_id;
                        res_id_q     <= grant_id;
                        if (sel_denom == '0) begin
                            res_quot_q    <= '1;
                            res_divzero_q <= 1'b1;
                            res_timeout_q <= 1'b0;
                            res_valid_q   <= 1'b1;
                            state_q       <= S_RESP;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 16'd1;
                    // A done arriving on the final wait cycle still counts.
                    if (div_done_i) begin
                        res_quot_q    <= div_quot_i;
                        res_divzero_q <= 1'b0;
                        res_timeout_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        res_quot_q    <= '0;
                        res_divzero_q <= 1'b0;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_start_o   = div_start_q;
    assign div_numer_o   = div_numer_q;
    assign div_denom_o   = div_denom_q;
    assign res_valid_o   = res_valid_q;
    assign res_id_o      = res_id_q;
    assign res_quot_o    = res_quot_q;
    assign res_divzero_o = res_divzero_q;
    assign res_timeout_o = res_timeout_q;
    assign busy_o        = (state_q != S_IDLE);
    assign state_o       = state_q;

endmodule
